// File: rtl/pc_seq_pkg.sv
// Shared types and decoder opcode constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [4:0] OP_JE   = 5'b00011;
    localparam logic [4:0] OP_JZ   = 5'b00100;
    localparam logic [4:0] OP_JGT  = 5'b11001;
    localparam logic [4:0] OP_JLT  = 5'b11010;
    localparam logic [4:0] OP_CALL = 5'b01011;
    localparam logic [4:0] OP_RET  = 5'b01100;

    // Decoder helper: opcodes that must raise the jump strobe.
    function automatic logic is_jump_op(input logic [4:0] op);
        return (op == OP_JE) || (op == OP_JZ) || (op == OP_JGT) ||
               (op == OP_JLT) || (op == OP_CALL) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO. The top entry comes only from registered state,
// so a push never feeds through to top in the same cycle.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] depth
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] top_idx;

    assign top_idx = AW'(depth - DW'(1));
    assign top     = mem[top_idx];
    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (clear) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

    // NOTE: storage has no reset; entries above depth are never read, so it maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(depth)] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, a return-address stack and the
// IDLE/RUN/HALT execution state with start/done handshaking.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int RS_DEPTH = 4,
    parameter int START_PC = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          halt,
    input  logic                          jump,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          taken,
    input  logic [PC_W-1:0]               target,
    output logic [PC_W-1:0]               pc,
    output logic                          pc_valid,
    output logic                          done,
    output logic [$clog2(RS_DEPTH+1)-1:0] rs_depth,
    output logic                          rs_err
);

    localparam logic [PC_W-1:0] START = PC_W'(START_PC);

    state_t          state;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] rs_top;
    logic            rs_full;
    logic            rs_empty;
    logic            advance;
    logic            do_ret;
    logic            do_call;
    logic            rs_push;
    logic            rs_pop;
    logic            rs_clear;

    // Wraps modulo 2^PC_W; the pushed return address wraps the same way.
    assign pc_inc   = pc + PC_W'(1);

    assign advance  = (state == RUN) && !stall && !halt;
    assign do_ret   = advance && jump && ret;
    assign do_call  = advance && jump && call && !ret;
    assign rs_push  = do_call && !rs_full;
    assign rs_pop   = do_ret && !rs_empty;
    assign rs_clear = (state == HALT) && start;

    assign done     = (state == HALT);
    assign pc_valid = (state == RUN) && !stall;

    return_stack #(
        .DEPTH (RS_DEPTH),
        .W     (PC_W)
    ) u_rs (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rs_push),
        .pop   (rs_pop),
        .clear (rs_clear),
        .din   (pc_inc),
        .top   (rs_top),
        .full  (rs_full),
        .empty (rs_empty),
        .depth (rs_depth)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= START;
            rs_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= START;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            state <= HALT;
                        end else if (jump && ret) begin
                            if (rs_empty) begin
                                rs_err <= 1'b1;
                                state  <= HALT;
                            end else begin
                                pc <= rs_top;
                            end
                        end else if (jump && call) begin
                            if (rs_full) begin
                                rs_err <= 1'b1;
                                state  <= HALT;
                            end else begin
                                pc <= target;
                            end
                        end else if (jump && taken) begin
                            pc <= target;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        state  <= RUN;
                        pc     <= START;
                        rs_err <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default 10-bit instance plus a 4-bit
// instance for PC wrap-around.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stall, halt, jump, call, ret, taken;
    logic [9:0] target, pc;
    logic       pc_valid, done, rs_err;
    logic [2:0] rs_depth;

    logic       b_rst_n, b_start, b_jump, b_call, b_ret;
    logic [3:0] b_target, b_pc;
    logic       b_pc_valid, b_done, b_rs_err;
    logic [2:0] b_rs_depth;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .jump(jump), .call(call), .ret(ret), .taken(taken), .target(target),
        .pc(pc), .pc_valid(pc_valid), .done(done), .rs_depth(rs_depth), .rs_err(rs_err)
    );

    pc_sequencer #(.PC_W(4), .RS_DEPTH(4), .START_PC(0)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .stall(1'b0), .halt(1'b0),
        .jump(b_jump), .call(b_call), .ret(b_ret), .taken(1'b0), .target(b_target),
        .pc(b_pc), .pc_valid(b_pc_valid), .done(b_done), .rs_depth(b_rs_depth), .rs_err(b_rs_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic j, input logic c, input logic r, input logic t,
                           input logic [9:0] tgt);
        jump = j; call = c; ret = r; taken = t; target = tgt;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; stall = 0; halt = 0;
        strobes(0, 0, 0, 0, 10'd0);
        b_rst_n = 1'b0; b_start = 0; b_jump = 0; b_call = 0; b_ret = 0; b_target = 4'd0;

        #12;
        check("rst_pc", pc, 0);
        check("rst_valid", pc_valid, 0);
        check("rst_done", done, 0);
        check("rst_depth", rs_depth, 0);
        check("rst_err", rs_err, 0);

        @(negedge clk); rst_n = 1'b1;
        tick();
        check("idle_pc", pc, 0);
        check("idle_valid", pc_valid, 0);

        start = 1; tick(); start = 0;
        check("start_pc", pc, 0);
        check("start_valid", pc_valid, 1);
        check("start_done", done, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("count_pc", pc, i);
        end

        strobes(1, 0, 0, 0, 10'd40); tick();
        check("not_taken_pc", pc, 6);
        strobes(1, 0, 0, 1, 10'd40); tick();
        check("taken_pc", pc, 40);

        strobes(1, 1, 0, 0, 10'd100); tick();
        check("call_pc", pc, 100);
        check("call_depth", rs_depth, 1);
        strobes(1, 0, 1, 0, 10'd0); tick();
        check("ret_pc", pc, 41);
        check("ret_depth", rs_depth, 0);

        strobes(1, 1, 0, 0, 10'd200); tick();
        strobes(1, 1, 0, 0, 10'd300); tick();
        strobes(1, 1, 0, 0, 10'd400); tick();
        strobes(1, 1, 0, 0, 10'd500); tick();
        check("nest_pc", pc, 500);
        check("nest_depth", rs_depth, 4);
        strobes(1, 0, 1, 0, 10'd0);
        tick(); check("nest_ret1", pc, 401); check("nest_d1", rs_depth, 3);
        tick(); check("nest_ret2", pc, 301); check("nest_d2", rs_depth, 2);
        tick(); check("nest_ret3", pc, 201); check("nest_d3", rs_depth, 1);
        tick(); check("nest_ret4", pc, 42);  check("nest_d4", rs_depth, 0);

        stall = 1; strobes(1, 0, 0, 1, 10'd50);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 42);
            check("stall_valid", pc_valid, 0);
        end
        stall = 0; #1;
        check("unstall_valid", pc_valid, 1);
        tick();
        check("unstall_pc", pc, 50);

        strobes(1, 1, 0, 0, 10'd60); tick();
        strobes(1, 1, 0, 0, 10'd70); tick();
        strobes(1, 1, 0, 0, 10'd80); tick();
        strobes(1, 1, 0, 0, 10'd90); tick();
        check("fill_depth", rs_depth, 4);
        strobes(1, 1, 0, 0, 10'd99); tick();
        check("ovf_err", rs_err, 1);
        check("ovf_done", done, 1);
        check("ovf_pc", pc, 90);
        check("ovf_depth", rs_depth, 4);
        check("ovf_valid", pc_valid, 0);
        strobes(1, 0, 0, 1, 10'd5); tick();
        check("halt_hold_pc", pc, 90);

        strobes(0, 0, 0, 0, 10'd0);
        start = 1; tick();
        check("restart_pc", pc, 0);
        check("restart_err", rs_err, 0);
        check("restart_depth", rs_depth, 0);
        check("restart_done", done, 0);
        tick();
        check("start_in_run_pc", pc, 1);
        start = 0; tick();
        check("pre_udf_pc", pc, 2);

        strobes(1, 0, 1, 0, 10'd0); tick();
        check("udf_err", rs_err, 1);
        check("udf_done", done, 1);
        check("udf_pc", pc, 2);
        strobes(0, 0, 0, 0, 10'd0);
        start = 1; tick(); start = 0;
        check("udf_restart_err", rs_err, 0);

        strobes(1, 1, 0, 0, 10'd100); tick();
        strobes(1, 1, 1, 0, 10'd300); tick();
        check("callret_pc", pc, 1);
        check("callret_depth", rs_depth, 0);

        halt = 1; strobes(1, 0, 0, 1, 10'd77); tick();
        halt = 0; strobes(0, 0, 0, 0, 10'd0);
        check("halt_pc", pc, 1);
        check("halt_done", done, 1);
        start = 1; tick(); start = 0;
        check("halt_restart_pc", pc, 0);

        strobes(1, 1, 0, 0, 10'd100); tick();
        check("mid_call_pc", pc, 100);
        #2 rst_n = 1'b0;
        #1;
        check("async_pc", pc, 0);
        check("async_depth", rs_depth, 0);
        check("async_done", done, 0);
        check("async_valid", pc_valid, 0);
        strobes(0, 0, 0, 0, 10'd0);
        @(negedge clk); rst_n = 1'b1;

        b_rst_n = 1'b1;
        b_start = 1; tick(); b_start = 0;
        check("b_start_pc", b_pc, 0);
        repeat (15) tick();
        check("b_pc_max", b_pc, 15);
        tick();
        check("b_wrap_pc", b_pc, 0);
        repeat (15) tick();
        b_jump = 1; b_call = 1; b_target = 4'd3; tick();
        check("b_call_pc", b_pc, 3);
        check("b_call_depth", b_rs_depth, 1);
        b_call = 0; b_ret = 1; tick();
        check("b_ret_wrap_pc", b_pc, 0);
        check("b_ret_depth", b_rs_depth, 0);
        b_jump = 0; b_ret = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the single-cycle core: owns the PC register and a hardware return-address stack.
- Consumes the decoder's jump/call/ret strobes, a branch-condition input, a memory stall and a halt strobe; drives the fetch address.
- Sits between the instruction decoder/ALU flags and instruction memory.
- Also provides start/done handshaking to the testbench or top level.

Parameters:
- PC_W, 10, PC and target width in bits.
- RS_DEPTH, 4, return-stack entries (power of 2, >=2).
- START_PC, 0, PC loaded on start.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  begin/restart execution; sampled in IDLE or HALT.
- stall  in  1  hold PC this cycle (multi-cycle memory access).
- halt  in  1  decoded halt instruction.
- jump  in  1  control-transfer strobe from decoder (JE/JZ/JGT/JLT/call/ret).
- call  in  1  call strobe; always paired with jump.
- ret  in  1  return strobe; always paired with jump.
- taken  in  1  branch condition met; ignored for call/ret.
- target  in  PC_W  absolute jump/call destination.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  high in RUN when stall=0.
- done  out  1  high in HALT.
- rs_depth  out  $clog2(RS_DEPTH+1)  current stack occupancy.
- rs_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, pc=START_PC, rs_depth=0, rs_err=0, pc_valid=0, done=0; stack contents don't-care.
- States: IDLE, RUN, HALT. done=(state==HALT); pc_valid=(state==RUN && !stall).
- IDLE: start=1 -> RUN; pc=START_PC.
- HALT: start=1 -> RUN; pc=START_PC, rs_depth=0, rs_err=0. All other inputs ignored.
- RUN with stall=1: pc, stack and state hold; every strobe ignored that cycle. The decoder re-presents the same strobes when the stall clears.
- RUN with stall=0, one action per cycle, priority highest first:
  1. halt -> HALT; pc holds.
  2. jump&ret: if rs_depth>0, pc=top entry and rs_depth-1. If rs_depth==0 (underflow), rs_err=1, HALT, pc holds.
  3. jump&call: if rs_depth<RS_DEPTH, push pc+1, pc=target, rs_depth+1. If full (overflow), rs_err=1, HALT, no push, pc holds.
  4. jump&taken (not call/ret): pc=target.
  5. Otherwise: pc=pc+1.
- Arithmetic: pc+1 is modulo 2^PC_W; at all-ones, wraps to 0 with no flag. A pushed return address of pc+1 wraps the same way.
- Latency: every redirect takes effect on the pc the next cycle (1-cycle). No delay slot.
- Simultaneous call and ret in one cycle is illegal decode; ret wins per priority.
- start while in RUN is ignored.
- Reset asserted mid-operation overrides everything immediately.

Decomposition:
- Package pc_seq_pkg: state enum (IDLE, RUN, HALT) and opcode constants shared with the decoder: JE=00011, JZ=00100, JGT=11001, JLT=11010, CALL=01011, RET=01100.
- Sub-module return_stack: LIFO with push, pop, full, empty, top and depth. Same Clk/Reset; no combinational path from push to top.

Test Plan:
- Reset then start with no strobes -> pc=0 the cycle after start, then 1,2,3...; pc_valid=1; done=0.
- At pc=5: jump=1, taken=0 -> pc=6. At pc=6: jump=1, taken=1, target=40 -> pc=40.
- At pc=10: call, target=100 -> pc=100, rs_depth=1. Then ret -> pc=11, rs_depth=0. Nested 4 calls then 4 rets return in LIFO order.
- 5th call with RS_DEPTH=4 -> rs_err=1, done=1, pc unchanged, rs_depth=4. Separately, ret at depth 0 -> rs_err=1, HALT.
- At pc=20: stall held 3 cycles with jump&taken, target=50 asserted -> pc=20 throughout, pc_valid=0. After stall drops with the strobe still present -> pc=50.
- PC_W=4, free-run from 15 -> pc=0 next. Halt then start -> pc=0, rs_err=0, RUN. Reset asserted mid-call -> pc=0, IDLE asynchronously.
